// File: rtl/exe_mul_sequencer.sv
// exe_mul_sequencer: multi-cycle radix-2 shift-add multiply controller for the EXE stage.
// Latches the operands, performs N fixed add/shift iterations while stalling the
// pipeline, then presents the low N bits of the product and the NZCV update for one cycle.
module exe_mul_sequencer #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         flushIn,
    input  logic [N-1:0] Val1In,
    input  logic [N-1:0] Val2In,
    input  logic         SIn,
    input  logic [3:0]   statusIn,
    output logic         stallOut,
    output logic         busyOut,
    output logic         doneOut,
    output logic [N-1:0] ResOut,
    output logic [3:0]   statusOut,
    output logic         statusWeOut
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [N-1:0]   acc;
    logic [N-1:0]   mcand;
    logic [N-1:0]   mplier;
    logic [N-1:0]   res_q;
    logic [CW-1:0]  count;
    logic           s_lat;
    logic           done_ok;

    // The completion cycle counts only if neither reset nor flush cancels it.
    assign done_ok = (state == DONE) && !flushIn && !rst;
    assign busyOut = (state != IDLE);

    // Next-state decode and combinational pipeline controls.
    always_comb begin
        state_next  = state;
        stallOut    = 1'b0;
        doneOut     = 1'b0;
        statusWeOut = 1'b0;
        statusOut   = '0;
        ResOut      = res_q;
        case (state)
            IDLE: begin
                if (start && !flushIn) begin
                    state_next = RUN;
                    stallOut   = 1'b1;
                end
            end
            RUN: begin
                stallOut = 1'b1;
                if (flushIn) begin
                    state_next = IDLE;
                end else if (count == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
                if (done_ok) begin
                    // Result is shown from acc during DONE and captured into res_q at
                    // its end, so a flush in DONE leaves the previous result visible.
                    ResOut      = acc;
                    doneOut     = 1'b1;
                    statusWeOut = s_lat;
                    statusOut   = {acc[N-1], (acc == '0), statusIn[1], statusIn[0]};
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, operand latches and shift-add datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            res_q  <= '0;
            s_lat  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start && !flushIn) begin
                        mcand  <= Val1In;
                        mplier <= Val2In;
                        s_lat  <= SIn;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                end
                DONE: begin
                    if (done_ok) begin
                        res_q <= acc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exe_mul_sequencer.sv
// tb_exe_mul_sequencer: directed self-checking bench for exe_mul_sequencer (N=32).
module tb_exe_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flushIn;
    logic [31:0] Val1In;
    logic [31:0] Val2In;
    logic        SIn;
    logic [3:0]  statusIn;
    logic        stallOut;
    logic        busyOut;
    logic        doneOut;
    logic [31:0] ResOut;
    logic [3:0]  statusOut;
    logic        statusWeOut;

    int checks   = 0;
    int failures = 0;

    exe_mul_sequencer #(.N(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .flushIn    (flushIn),
        .Val1In     (Val1In),
        .Val2In     (Val2In),
        .SIn        (SIn),
        .statusIn   (statusIn),
        .stallOut   (stallOut),
        .busyOut    (busyOut),
        .doneOut    (doneOut),
        .ResOut     (ResOut),
        .statusOut  (statusOut),
        .statusWeOut(statusWeOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Advance to the sampling point of the next cycle (1 time unit after the falling edge).
    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    // Drives one MUL from the current cycle (cycle 0) and checks it through DONE.
    // Returns in the DONE cycle; start is released there unless keep_start is set.
    task automatic do_run(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [3:0] st,
                          input logic [31:0] exp_res, input logic [3:0] exp_status,
                          input logic keep_start);
        int cyc = 0;
        int stalls = 0;
        start    = 1'b1;
        Val1In   = a;
        Val2In   = b;
        SIn      = s;
        statusIn = st;
        #1;
        check({tag, "_busy_c0"}, 32'(busyOut), 32'd0);
        while (!doneOut && cyc < 100) begin
            if (stallOut) stalls++;
            next_cycle();
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'd33);
        check({tag, "_stalls"}, 32'(stalls), 32'd33);
        check({tag, "_stall_done"}, 32'(stallOut), 32'd0);
        check({tag, "_res"}, ResOut, exp_res);
        check({tag, "_we"}, 32'(statusWeOut), 32'(s));
        check({tag, "_nzcv"}, 32'(statusOut), 32'(exp_status));
        if (!keep_start) start = 1'b0;
    endtask

    initial begin
        int pulses;
        rst      = 1'b1;
        start    = 1'b0;
        flushIn  = 1'b0;
        Val1In   = '0;
        Val2In   = '0;
        SIn      = 1'b0;
        statusIn = 4'b0000;
        next_cycle();
        next_cycle();
        check("rst_res", ResOut, 32'd0);
        check("rst_nzcv", 32'(statusOut), 32'd0);
        check("rst_done", 32'(doneOut), 32'd0);
        check("rst_we", 32'(statusWeOut), 32'd0);
        check("rst_stall", 32'(stallOut), 32'd0);
        check("rst_busy", 32'(busyOut), 32'd0);
        rst = 1'b0;
        next_cycle();

        // Basic 3*5, flags not written.
        do_run("basic", 32'd3, 32'd5, 1'b0, 4'b0000, 32'd15, 4'b0000, 1'b0);
        next_cycle();
        check("basic_done_once", 32'(doneOut), 32'd0);
        check("basic_res_hold", ResOut, 32'd15);

        // Wrap: (2^32-1)^2 mod 2^32 = 1; C,V pass through.
        do_run("wrap", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'b0011, 32'd1, 4'b0011, 1'b0);
        next_cycle();
        check("wrap_we_after", 32'(statusWeOut), 32'd0);

        // Zero result sets Z.
        do_run("zero", 32'h0001_0000, 32'h0001_0000, 1'b1, 4'b0000, 32'd0, 4'b0100, 1'b0);
        next_cycle();

        // Negative result sets N, C passes through.
        do_run("neg", 32'h4000_0000, 32'd2, 1'b1, 4'b0010, 32'h8000_0000, 4'b1010, 1'b0);
        next_cycle();

        // Back-to-back: start held through DONE, second MUL begins the cycle after.
        do_run("b2b1", 32'd3, 32'd5, 1'b0, 4'b0000, 32'd15, 4'b0000, 1'b1);
        Val1In = 32'd7;
        Val2In = 32'd6;
        next_cycle();
        check("b2b_idle_stall", 32'(stallOut), 32'd1);
        do_run("b2b2", 32'd7, 32'd6, 1'b0, 4'b0000, 32'd42, 4'b0000, 1'b0);
        next_cycle();

        // Flush at RUN cycle 10 of 12*12.
        start  = 1'b1;
        Val1In = 32'd12;
        Val2In = 32'd12;
        SIn    = 1'b1;
        repeat (10) next_cycle();
        check("flush_busy_run", 32'(busyOut), 32'd1);
        flushIn = 1'b1;
        start   = 1'b0;
        next_cycle();
        flushIn = 1'b0;
        check("flush_busy", 32'(busyOut), 32'd0);
        check("flush_stall", 32'(stallOut), 32'd0);
        check("flush_res_hold", ResOut, 32'd42);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (doneOut || statusWeOut) pulses++;
            next_cycle();
        end
        check("flush_no_done", 32'(pulses), 32'd0);

        // Flush in IDLE with start: no run, no stall.
        start   = 1'b1;
        flushIn = 1'b1;
        #1;
        check("idle_flush_stall", 32'(stallOut), 32'd0);
        next_cycle();
        start   = 1'b0;
        flushIn = 1'b0;
        check("idle_flush_busy", 32'(busyOut), 32'd0);

        // Reset at RUN cycle 20 of 100*100.
        start  = 1'b1;
        Val1In = 32'd100;
        Val2In = 32'd100;
        repeat (20) next_cycle();
        rst   = 1'b1;
        start = 1'b0;
        next_cycle();
        rst = 1'b0;
        check("mrst_busy", 32'(busyOut), 32'd0);
        check("mrst_stall", 32'(stallOut), 32'd0);
        check("mrst_res", ResOut, 32'd0);
        check("mrst_done", 32'(doneOut), 32'd0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (doneOut) pulses++;
            next_cycle();
        end
        check("mrst_no_done", 32'(pulses), 32'd0);
        do_run("after_rst", 32'd9, 32'd9, 1'b0, 4'b0000, 32'd81, 4'b0000, 1'b0);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exe_mul_sequencer.md
Name: exe_mul_sequencer

Overview:
- Multi-cycle multiply controller alongside the EXE stage.
- Handles MUL-class instructions that the single-cycle ALU cannot execute: latches Val1/Val2, runs a radix-2 shift-add sequence over N cycles and stalls the pipeline.
- On completion, presents the low N bits of the product and the NZCV update for the status register.

Parameters:
N, 32, operand/result width; also the iteration count.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  EXE holds a MUL instruction; level, held while stalled
flushIn  input  1  synchronous cancel of the operation in flight (branch taken)
Val1In  input  N  multiplicand
Val2In  input  N  multiplier
SIn  input  1  instruction S bit: update flags on completion
statusIn  input  4  current NZCV from status register, [3]=N [2]=Z [1]=C [0]=V
stallOut  output  1  freeze PC, IF/ID, ID/EXE registers
busyOut  output  1  state != IDLE
doneOut  output  1  one-cycle pulse: ResOut valid
ResOut  output  N  low N bits of Val1In*Val2In
statusOut  output  4  NZCV to write
statusWeOut  output  1  status register write enable, one cycle

Behaviour:
- Reset: state=IDLE, acc/mcand/mplier/count=0. ResOut=0, statusOut=0, doneOut=0, statusWeOut=0, stallOut=0, busyOut=0.
- Reset has priority over flushIn, and both have priority over start.
- States:
  - IDLE
    - start=1: latch mcand=Val1In, mplier=Val2In, S_lat=SIn; acc=0, count=0; go to RUN.
    - stallOut=start, combinational, so the pipeline freezes in the same cycle.
  - RUN
    - Each cycle: if mplier[0], acc = acc+mcand mod 2^N. Then mcand <<= 1, mplier >>= 1, count++.
    - After the N-th iteration (count==N-1 processed) go to DONE.
    - Fixed latency, no early exit. stallOut=1.
  - DONE
    - ResOut=acc (registered, held until the next completion). doneOut=1.
    - statusWeOut=S_lat; statusOut={acc[N-1], acc==0, statusIn[1], statusIn[0]}. C and V pass through unchanged.
    - stallOut=0, so the pipeline advances at this edge. Next state is IDLE.
- Timing: start seen in IDLE at cycle 0. RUN occupies cycles 1..N. DONE is cycle N+1. Stall is asserted for cycles 0..N (N+1 cycles).
- start while in RUN or DONE is ignored; it is the same held instruction. start high in the cycle after DONE is a new instruction and triggers a new run.
- flushIn in RUN or DONE: next state IDLE. No doneOut and no statusWeOut afterwards; a flush in DONE suppresses that cycle's doneOut and statusWeOut. ResOut retains its previous value.
- flushIn in IDLE with start=1: the run does not begin, and stallOut=0 that cycle.
- Reset mid-RUN: all state and outputs return to reset values next cycle. No done pulse.
- Arithmetic is unsigned shift-add, truncated to N bits. Low N bits equal the two's-complement product, so signed MUL needs no special handling.
- statusOut and statusWeOut are valid only while doneOut=1. Otherwise statusWeOut=0.

Test Plan:
- Basic: Val1=3, Val2=5, SIn=0, start held.
  - stallOut=1 for 33 cycles; doneOut pulses at cycle 33.
  - ResOut=15, statusWeOut=0.
- Wrap/flags: Val1=Val2=0xFFFFFFFF, SIn=1, statusIn=4'b0011 -> ResOut=0x00000001, statusOut=4'b0011, statusWeOut=1.
- Zero/negative:
  - 0x10000 * 0x10000, SIn=1 -> ResOut=0, Z=1.
  - 0x40000000 * 2 -> ResOut=0x80000000, N=1, Z=0.
- Back-to-back: start held through DONE, then start stays high for a second MUL (7*6).
  - No retrigger in DONE.
  - Second run begins the cycle after DONE; ResOut=42 at its done.
- Flush: flushIn=1 at RUN cycle 10 of 12*12 -> IDLE next cycle, no doneOut, ResOut keeps its old value, stallOut=0.
- Reset mid-run: rst=1 at RUN cycle 20 -> all outputs 0 next cycle. A subsequent 9*9 completes normally with ResOut=81.
